// File: rtl/serial_receiver_if.sv
// Byte output port of the serial receiver: valid/ready handshake carrying one received byte.
interface serial_receiver_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/serial_receiver.sv
// Receive end of the 3-wire serial link (transmission, transmission_clock, data).
// Oversamples the link, rebuilds LSB-first bytes and offers them on a valid/ready port.
// Optional feature macro: SERIAL_RX_FIFO_EN replaces the single holding register with a
// FIFO_DEPTH-entry first-word-fall-through FIFO.
module serial_receiver #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              transmission,
  input  logic              transmission_clock,
  input  logic              in_data,
  serial_receiver_if.master out_if,
  output logic              frame_error,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StReceive, StCommit, StWaitEnd} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   frame_error_q, frame_error_d;
  logic                   overrun_q;
  logic                   push;
  logic                   pop;

  logic [SYNC_STAGES-1:0] tx_sync_q, lclk_sync_q, data_sync_q;
  logic                   tx_prev_q, lclk_prev_q;
  logic [SYNC_STAGES:0]   arm_q;
  logic                   tx_s, lclk_s, data_s;
  logic                   armed, line_edge, tx_rise;

  assign tx_s   = tx_sync_q[SYNC_STAGES-1];
  assign lclk_s = lclk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Edge detection is held off until the sync chains and the previous-sample flops carry real
  // line values, so a line idling high after reset never looks like an edge.
  assign armed     = arm_q[SYNC_STAGES];
  assign line_edge = armed & (lclk_s ^ lclk_prev_q);
  assign tx_rise   = armed & tx_s & ~tx_prev_q;

  // Input synchronizers (equal depth keeps the three lines aligned) and edge-detect history.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sync_q   <= '0;
      lclk_sync_q <= '0;
      data_sync_q <= '0;
      tx_prev_q   <= 1'b0;
      lclk_prev_q <= 1'b0;
      arm_q       <= '0;
    end else begin
      tx_sync_q   <= {tx_sync_q[SYNC_STAGES-2:0], transmission};
      lclk_sync_q <= {lclk_sync_q[SYNC_STAGES-2:0], transmission_clock};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], in_data};
      tx_prev_q   <= tx_s;
      lclk_prev_q <= lclk_s;
      arm_q       <= {arm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Frame FSM state, bit counter, shift register and frame-error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      shift_q       <= shift_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next-state logic; an edge's bit is taken before a same-cycle fall of transmission is judged.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shift_d       = shift_q;
    frame_error_d = 1'b0;
    push          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_rise) begin
          state_d = StReceive;
          count_d = '0;
          shift_d = '0;
        end
      end
      StReceive: begin
        if (line_edge) begin
          shift_d[count_q[CW-2:0]] = data_s;
          count_d                  = count_q + CW'(1);
        end
        if (count_d == CW'(DATA_WIDTH)) begin
          state_d = StCommit;
        end else if (!tx_s) begin
          state_d       = StIdle;
          frame_error_d = (count_d != '0);
        end
      end
      StCommit: begin
        push    = 1'b1;
        state_d = StWaitEnd;
      end
      StWaitEnd: begin
        if (!tx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop = out_if.out_valid & out_if.out_ready;

`ifdef SERIAL_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic                  empty, full, accept;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop in the same cycle frees the head slot, so a full FIFO still takes the byte.
  assign accept = push & (~full | pop);

  // FIFO pointers and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept)          wr_ptr_q  <= wr_ptr_q + (AW+1)'(1);
      if (pop)             rd_ptr_q  <= rd_ptr_q + (AW+1)'(1);
      if (push && !accept) overrun_q <= 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  assign out_if.out_valid = ~empty;
  assign out_if.out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  valid_q;

  // Single holding register; a new byte that finds it occupied is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (push && (!valid_q || pop)) begin
      hold_q  <= shift_q;
      valid_q <= 1'b1;
    end else if (push) begin
      overrun_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = hold_q;
`endif

  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q == StReceive);

endmodule

// File: tb/tb_serial_receiver.sv
// Directed self-checking bench for serial_receiver; expectations follow SERIAL_RX_FIFO_EN.
module tb_serial_receiver;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  logic transmission;
  logic transmission_clock;
  logic in_data;
  logic frame_error;
  logic overrun;
  logic busy;

  int checks    = 0;
  int failures  = 0;
  int valid_cyc = 0;
  int fe_cnt    = 0;
  int fe_base;
  logic [7:0] rx_q[$];

  serial_receiver_if #(.DATA_WIDTH(DW)) bus ();

  serial_receiver #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .transmission      (transmission),
    .transmission_clock(transmission_clock),
    .in_data           (in_data),
    .out_if            (bus),
    .frame_error       (frame_error),
    .overrun           (overrun),
    .busy              (busy)
  );

  always #5 clk = ~clk;

`ifdef SERIAL_RX_FIFO_EN
  localparam bit FifoEn = 1'b1;
`else
  localparam bit FifoEn = 1'b0;
`endif

  // Monitor on the falling edge: record accepted bytes, valid cycles and error pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid && bus.out_ready) rx_q.push_back(bus.out_data);
      if (bus.out_valid) valid_cyc++;
      if (frame_error) fe_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] q_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  // One frame: nbits LSB-first bits at 8 clk per bit, then transmission low for gap clk.
  task automatic send_frame(input logic [7:0] b, input int nbits, input int gap);
    transmission = 1'b1;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      in_data            = b[i];
      transmission_clock = ~transmission_clock;
      tick(8);
      if (i == 0) check("busy_in_frame", 32'(busy), 32'd1);
    end
    transmission = 1'b0;
    tick(gap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
  endtask

  initial begin
    reset              = 1'b1;
    transmission       = 1'b0;
    transmission_clock = 1'b1;
    in_data            = 1'b0;
    bus.out_ready      = 1'b0;
    tick(3);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
    tick(4);

    // 1: single 0xA5 frame with consumer always ready
    bus.out_ready = 1'b1;
    rx_q.delete();
    valid_cyc = 0;
    send_frame(8'hA5, 8, 6);
    tick(4);
    check("t1_count", 32'(rx_q.size()), 32'd1);
    check("t1_byte", 32'(q_at(0)), 32'hA5);
    check("t1_valid_cycles", 32'(valid_cyc), 32'd1);
    check("t1_frame_error", 32'(fe_cnt), 32'd0);
    check("t1_overrun", 32'(overrun), 32'd0);

    // 2: 0x3C truncated after 5 bits
    rx_q.delete();
    send_frame(8'h3C, 5, 6);
    tick(4);
    check("t2_fe_pulses", 32'(fe_cnt), 32'd1);
    check("t2_count", 32'(rx_q.size()), 32'd0);
    check("t2_valid", 32'(bus.out_valid), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // 3: consumer stalled for 0x11 then 0x22
    bus.out_ready = 1'b0;
    rx_q.delete();
    send_frame(8'h11, 8, 6);
    send_frame(8'h22, 8, 6);
    tick(4);
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    check("t3_head", 32'(bus.out_data), 32'h11);
    check("t3_overrun", 32'(overrun), FifoEn ? 32'd0 : 32'd1);
    bus.out_ready = 1'b1;
    tick(4);
    bus.out_ready = 1'b0;
    check("t3_count", 32'(rx_q.size()), FifoEn ? 32'd2 : 32'd1);
    check("t3_first", 32'(q_at(0)), 32'h11);
    if (FifoEn) check("t3_second", 32'(q_at(1)), 32'h22);
    check("t3_valid_after", 32'(bus.out_valid), 32'd0);

    // 4: five frames into a stalled consumer
    do_reset();
    rx_q.delete();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 6);
    tick(4);
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_head", 32'(bus.out_data), 32'h01);
    bus.out_ready = 1'b1;
    tick(8);
    bus.out_ready = 1'b0;
    check("t4_count", 32'(rx_q.size()), FifoEn ? 32'd4 : 32'd1);
    for (int i = 0; i < (FifoEn ? 4 : 1); i++) check("t4_byte", 32'(q_at(i)), 32'(i + 1));
    check("t4_valid_after", 32'(bus.out_valid), 32'd0);

    // 5: reset at bit 4 of 0xFF, then a clean 0x81
    bus.out_ready = 1'b1;
    rx_q.delete();
    fe_base      = fe_cnt;
    transmission = 1'b1;
    tick(4);
    for (int i = 0; i < 4; i++) begin
      in_data            = 1'b1;
      transmission_clock = ~transmission_clock;
      tick(8);
    end
    reset        = 1'b1;
    transmission = 1'b0;
    tick(1);
    check("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t5_rst_data", 32'(bus.out_data), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_overrun", 32'(overrun), 32'd0);
    check("t5_rst_fe", 32'(frame_error), 32'd0);
    reset = 1'b0;
    tick(4);
    send_frame(8'h81, 8, 6);
    tick(4);
    check("t5_count", 32'(rx_q.size()), 32'd1);
    check("t5_byte", 32'(q_at(0)), 32'h81);
    check("t5_no_fe", 32'(fe_cnt), 32'(fe_base));

    // 6: line clock idling high through reset, back-to-back 0x00/0xFF with 2 clk gap
    reset              = 1'b1;
    transmission_clock = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    rx_q.delete();
    fe_base = fe_cnt;
    send_frame(8'h00, 8, 2);
    send_frame(8'hFF, 8, 6);
    tick(4);
    check("t6_count", 32'(rx_q.size()), 32'd2);
    check("t6_first", 32'(q_at(0)), 32'h00);
    check("t6_second", 32'(q_at(1)), 32'hFF);
    check("t6_no_fe", 32'(fe_cnt), 32'(fe_base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
